down_timer: RTL

Loadable down-counting interval timer, the counterpart of the team's 4-bit ripple-carry up-counter. It counts a preloaded value down to zero, emits ripple-borrow outputs so stages can be chained the same way the up-counter chains its carries, and signals expiry with a registered one-cycle `done` pulse. It sits beside the up-counter in the timing/sequencing datapath. It either stops at zero (one-shot) or reloads and keeps running (auto-reload).

---
 rtl/down_timer_pkg.sv | 12 +
 rtl/down_timer_dn_bit.sv | 27 ++
 rtl/down_timer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer slice: FSM state encoding and the
// default counter width.
package down_timer_pkg;

    localparam int TMR_WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/down_timer_dn_bit.sv
// One-bit down-count slice. A slice toggles when a borrow arrives from below
// and passes a borrow upward only while it is itself zero, so a chain of
// slices forms a ripple down-counter.
module dn_bit (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic load_bit,
    input  logic bin,
    output logic q,
    output logic bout
);

    // Bit register: reset, parallel load, or toggle on borrow-in.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else if (load) begin
            q <= load_bit;
        end else if (bin) begin
            q <= ~q;
        end
    end

    assign bout = bin & ~q;

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting interval timer built from a ripple chain of dn_bit
// slices. Optional feature macro: DOWN_TIMER_AUTORELOAD_EN (reload register
// and auto_rl handling); without it every expiry is one-shot.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | stopped; count holds, in_EN ignored, waiting for load
// ST_RUN  | counting down on in_EN; terminal count at zero with in_EN
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = TMR_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_EN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_rl,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             rbos,
    output logic             rbol
);

    tmr_state_e       state;
    tmr_state_e       state_nxt;
    logic             term;
    logic             auto_sel;
    logic [WIDTH-1:0] reload_val;
    logic             slice_load;
    logic [WIDTH-1:0] slice_val;

    assign busy = (state == ST_RUN);

    // Borrow chain: bit 0 sees the gated enable, each higher bit sees the
    // borrow-out of the bit below. The top borrow-out is the terminal count.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic b_in;
        logic b_out;
        if (i == 0) begin : g_first
            assign b_in = busy & in_EN;
        end else begin : g_rest
            assign b_in = g_bit[i-1].b_out;
        end
        dn_bit u_bit (
            .clk      (clk),
            .clr      (clr),
            .load     (slice_load),
            .load_bit (slice_val[i]),
            .bin      (b_in),
            .q        (count[i]),
            .bout     (b_out)
        );
    end

    assign rbos = g_bit[WIDTH-2].b_out;
    assign rbol = g_bit[WIDTH-1].b_out;
    assign term = rbol;

`ifdef DOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    // Reload register tracks every explicit load.
    always_ff @(posedge clk) begin
        if (clr) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= load_val;
        end
    end

    assign auto_sel   = auto_rl;
    assign reload_val = reload_q;
`else
    logic unused_auto_rl;

    assign unused_auto_rl = auto_rl;
    assign auto_sel       = 1'b0;
    assign reload_val     = '0;
`endif

    // The terminal cycle always loads the slices: the stored value when
    // reloading, zero otherwise, which keeps the chain from wrapping to all ones.
    assign slice_load = load | term;
    assign slice_val  = load     ? load_val   :
                        auto_sel ? reload_val : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: load beats terminal, terminal decides stop or rerun.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load) begin
                    state_nxt = ST_RUN;
                end else if (term && !auto_sel) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Expiry pulse, suppressed when a load lands on the terminal cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            done <= 1'b0;
        end else begin
            done <= term & ~load;
        end
    end

endmodule
